// File: rtl/p1_shift_pkg.sv
// Shared definitions for the P1 shift decoders and encoder: mode encoding,
// encoder FSM states and the default base pattern.
package p1_shift_pkg;

   localparam logic [1:0] MODE_LLS = 2'b00;
   localparam logic [1:0] MODE_RLS = 2'b01;
   localparam logic [1:0] MODE_LAS = 2'b10;
   localparam logic [1:0] MODE_RAS = 2'b11;

   localparam logic [4:0] P1_PATTERN_DEF = 5'b10100;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/p1_shift_pat.sv
// Combinational P1 pattern generator: (mode, amt) -> shifted PATTERN.
// RAS sign-fills only when P1_SHIFT_ENC_SIGN_FILL_EN is defined; otherwise RAS equals RLS.
module p1_shift_pat
   import p1_shift_pkg::*;
#(
   parameter int                 WIDTH   = 5,
   parameter int                 AMT_W   = 3,
   parameter logic [WIDTH-1:0]   PATTERN = WIDTH'(P1_PATTERN_DEF)
) (
   input  logic [1:0]       mode_i,
   input  logic [AMT_W-1:0] amt_i,
   output logic [WIDTH-1:0] pat_o
);

`ifdef P1_SHIFT_ENC_SIGN_FILL_EN
   localparam logic signed [WIDTH-1:0] PAT_S = PATTERN;
`endif

   always_comb begin
      pat_o = PATTERN >> amt_i;
      case (mode_i)
         MODE_LLS, MODE_LAS: pat_o = PATTERN << amt_i;
         MODE_RLS:           pat_o = PATTERN >> amt_i;
         MODE_RAS: begin
`ifdef P1_SHIFT_ENC_SIGN_FILL_EN
            pat_o = PAT_S >>> amt_i;
`else
            // PATTERN is unsigned, so the arithmetic shift zero-fills like RLS.
            pat_o = PATTERN >> amt_i;
`endif
         end
         default:            pat_o = PATTERN >> amt_i;
      endcase
   end

endmodule

// File: rtl/p1_shift_enc_seq.sv
// Sequential P1 shift encoder: sweeps every shift amount, reports smallest match, hit, ambiguity.
// Optional RAS sign fill via P1_SHIFT_ENC_SIGN_FILL_EN (handled inside p1_shift_pat).
module p1_shift_enc_seq
   import p1_shift_pkg::*;
#(
   parameter int               WIDTH   = 5,
   parameter logic [WIDTH-1:0] PATTERN = WIDTH'(P1_PATTERN_DEF),
   parameter int               AMT_W   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_code,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [AMT_W-1:0] out_amt,
   output logic             out_hit,
   output logic             out_multi
);

   state_e             state_q, state_d;
   logic [AMT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   code_q, code_d;
   logic [1:0]         mode_q, mode_d;
   logic [AMT_W-1:0]   amt_q, amt_d;
   logic               hit_q, hit_d;
   logic               multi_q, multi_d;
   logic [WIDTH-1:0]   pat;
   logic               match;

   p1_shift_pat #(
      .WIDTH   (WIDTH),
      .AMT_W   (AMT_W),
      .PATTERN (PATTERN)
   ) u_pat (
      .mode_i (mode_q),
      .amt_i  (cnt_q),
      .pat_o  (pat)
   );

   assign match     = (pat == code_q);
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_amt   = amt_q;
   assign out_hit   = hit_q;
   assign out_multi = multi_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      mode_d  = mode_q;
      amt_d   = amt_q;
      hit_d   = hit_q;
      multi_d = multi_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               code_d  = in_code;
               mode_d  = in_mode;
               cnt_d   = '0;
               amt_d   = '0;
               hit_d   = 1'b0;
               multi_d = 1'b0;
               state_d = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            if (match) begin
               if (!hit_q) begin
                  amt_d = cnt_q;
                  hit_d = 1'b1;
               end else begin
                  multi_d = 1'b1;
               end
            end
            // No early exit: latency is fixed regardless of where the match lands.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {AMT_W{1'b1}}) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         code_q  <= '0;
         mode_q  <= MODE_LLS;
         amt_q   <= '0;
         hit_q   <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         mode_q  <= mode_d;
         amt_q   <= amt_d;
         hit_q   <= hit_d;
         multi_q <= multi_d;
      end
   end

endmodule

// File: tb/tb_p1_shift_enc_seq.sv
// Directed bench for p1_shift_enc_seq; expected values hand-derived from PATTERN=10100.
module tb_p1_shift_enc_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] in_code;
   logic [1:0] in_mode;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_amt;
   logic       out_hit;
   logic       out_multi;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   p1_shift_enc_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_code   (in_code),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_amt   (out_amt),
      .out_hit   (out_hit),
      .out_multi (out_multi)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input string tag, input logic [4:0] code, input logic [1:0] mode,
                          input logic [2:0] e_amt, input logic e_hit, input logic e_multi,
                          input int stall, input bit poke);
      chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_code  = code;
      in_mode  = mode;
      tick();
      in_valid = 1'b0;
      in_code  = ~code;
      in_mode  = ~mode;
      chk({tag, " in_ready search"}, 32'(in_ready), 32'd0);
      for (int i = 1; i <= 8; i++) begin
         if (poke && i == 3) begin
            in_valid = 1'b1;
            in_code  = 5'b10100;
            in_mode  = 2'b01;
         end
         tick();
         in_valid = 1'b0;
         chk({tag, " out_valid latency"}, 32'(out_valid), (i == 8) ? 32'd1 : 32'd0);
      end
      chk({tag, " amt"},   32'(out_amt),   32'(e_amt));
      chk({tag, " hit"},   32'(out_hit),   32'(e_hit));
      chk({tag, " multi"}, 32'(out_multi), 32'(e_multi));
      for (int s = 0; s < stall; s++) begin
         tick();
         chk({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
         chk({tag, " stall in_ready"},  32'(in_ready),  32'd0);
         chk({tag, " stall amt"}, 32'({out_amt, out_hit, out_multi}), 32'({e_amt, e_hit, e_multi}));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      chk({tag, " in_ready back"},  32'(in_ready),  32'd1);
      chk({tag, " result held"}, 32'({out_amt, out_hit, out_multi}), 32'({e_amt, e_hit, e_multi}));
   endtask

   initial begin
      bit seen;
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_code   = 5'b01000;
      in_mode   = 2'b00;
      out_ready = 1'b1;
      tick();
      tick();
      tick();
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("reset in_ready",  32'(in_ready),  32'd1);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset result", 32'({out_amt, out_hit, out_multi}), 32'd0);

      run_req("lls_01000", 5'b01000, 2'b00, 3'd1, 1'b1, 1'b0, 0, 1'b0);
      run_req("rls_00001", 5'b00001, 2'b01, 3'd4, 1'b1, 1'b0, 0, 1'b0);
      run_req("rls_10100", 5'b10100, 2'b01, 3'd0, 1'b1, 1'b0, 0, 1'b0);
      run_req("lls_00000", 5'b00000, 2'b00, 3'd3, 1'b1, 1'b1, 5, 1'b0);
      run_req("rls_00000", 5'b00000, 2'b01, 3'd5, 1'b1, 1'b1, 0, 1'b1);
      run_req("rls_11111", 5'b11111, 2'b01, 3'd0, 1'b0, 1'b0, 0, 1'b0);
`ifdef P1_SHIFT_ENC_SIGN_FILL_EN
      run_req("ras_11010", 5'b11010, 2'b11, 3'd1, 1'b1, 1'b0, 0, 1'b0);
      run_req("ras_11111", 5'b11111, 2'b11, 3'd4, 1'b1, 1'b1, 0, 1'b0);
`else
      run_req("ras_11010", 5'b11010, 2'b11, 3'd0, 1'b0, 1'b0, 0, 1'b0);
      run_req("ras_00101", 5'b00101, 2'b11, 3'd2, 1'b1, 1'b0, 0, 1'b0);
`endif
      run_req("las_01000", 5'b01000, 2'b10, 3'd1, 1'b1, 1'b0, 0, 1'b0);

      // Reset while searching: the request must vanish without a result.
      in_valid = 1'b1;
      in_code  = 5'b01000;
      in_mode  = 2'b00;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst in_ready",  32'(in_ready),  32'd1);
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst result", 32'({out_amt, out_hit, out_multi}), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      chk("midrst no output", 32'(seen), 32'd0);
      run_req("post_rst_lls_10000", 5'b10000, 2'b00, 3'd2, 1'b1, 1'b0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
